router_pkt_gen: RTL
===================

ROUTER_PKT_GEN -- requirements
Module: router_pkt_gen

Interface
REQ-001 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1, request to send one packet; sampled only in IDLE.
REQ-004 SHALL have port addr, input, 2, destination port 0..2; value 3 is illegal.
REQ-005 SHALL have port len, input, 6, payload byte count 1..63; value 0 is illegal.
REQ-006 SHALL have port err_inject, input, 1, sampled with start; when set, the transmitted parity byte is inverted.
REQ-007 SHALL have port pl_data, input, 8, current payload byte from the show-ahead payload buffer.
REQ-008 SHALL have port pl_rd, output, 1, pop strobe to the payload buffer.
REQ-009 SHALL have port busy, input, 1, router busy; 1 means hold the current byte.
REQ-010 SHALL have port pkt_valid, output, 1, high during header and payload bytes.
REQ-011 SHALL have port data_out, output, 8, byte to the router data input.
REQ-012 SHALL have port ready, output, 1, generator idle and able to accept start.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after the parity byte is accepted.
REQ-014 SHALL have port cfg_err, output, 1, one-cycle pulse when start carries an illegal addr or len.
REQ-015 SHALL have port pkt_count, output, 16, count of completed packets; wraps from 0xFFFF to 0.

Function
REQ-016 SHALL implement the states IDLE, HEADER, PAYLOAD, PARITY and DONE.
REQ-017 In IDLE: ready=1, pkt_valid=0, data_out=0x00.
REQ-018 IDLE transitions:
- start=1 with legal addr/len: latch addr, len and err_inject; go to HEADER.
- start=1 with illegal addr/len: pulse cfg_err the next cycle; stay in IDLE.
REQ-019 In HEADER: pkt_valid=1, data_out={len,addr}; on a clock edge with busy=0, parity register <= header, byte counter <= 0, go to PAYLOAD.
REQ-020 In PAYLOAD: pkt_valid=1, data_out=pl_data (combinational), pl_rd=~busy.
REQ-021 On each PAYLOAD edge with busy=0: parity ^= pl_data and the counter increments; when the counter equals len-1, go to PARITY.
REQ-022 In PARITY: pkt_valid=0, data_out=parity, or ~parity if err_inject was latched; the byte is held while busy=1; on an edge with busy=0, go to DONE.
REQ-023 In DONE: done=1, pkt_count increments, pkt_valid=0, data_out=0x00; go to IDLE on the next edge.
REQ-024 While busy=1, data_out, pkt_valid and the state SHALL hold, and pl_rd SHALL be 0.
REQ-025 pl_rd SHALL be 0 in every state other than PAYLOAD.
REQ-026 start asserted outside IDLE SHALL be ignored, with no queuing and no cfg_err.
REQ-027 Minimum packet duration with busy=0 SHALL be len+3 cycles from entering HEADER through DONE, followed by 1 IDLE cycle before the next header.
REQ-028 Changes to addr, len or err_inject after the packet is latched SHALL have no effect on the packet in flight.

Reset
REQ-029 On reset=1 at a clock edge, the block SHALL:
- enter IDLE;
- clear pkt_valid, data_out, pl_rd, done, cfg_err, pkt_count, the parity register, the byte counter and the latched fields;
- set ready=1.
REQ-030 Reset mid-packet SHALL abort immediately, drop pkt_valid next cycle, and leave pkt_count unchanged.

Verification
REQ-031 Nominal packet: reset, busy=0, start with addr=1, len=3, payload 0x11,0x22,0x33. Required response:
- data_out sequence 0x0D,0x11,0x22,0x33 with pkt_valid=1;
- then 0x0D with pkt_valid=0;
- done pulse 1 cycle later, pkt_count=1.
REQ-032 Backpressure: same packet with busy=1 for 2 cycles while the second payload byte (0x22) is presented. Required response:
- 0x22 held for 3 cycles;
- pl_rd=0 during the busy cycles;
- parity still 0x0D.
REQ-033 Error injection: addr=2, len=1, payload 0xFF, err_inject=1. Required response:
- header 0x06;
- true parity 0xF9, so the transmitted parity is 0x06.
REQ-034 Illegal requests: start with addr=3, then start with len=0. Required response:
- two cfg_err pulses;
- pkt_valid never asserts;
- pkt_count stays 0.
REQ-035 Reset mid-packet: reset asserted during PAYLOAD. Required response:
- next cycle pkt_valid=0, ready=1, pkt_count unchanged;
- a fresh start then yields a correct packet.
REQ-036 Counter wrap: preload via 65536 len=1 packets (or a force). Required response: pkt_count wraps to 0x0000 and done still pulses.

Source files
------------

// File: rtl/router_pkt_gen.sv
// Router packet generator: sends header {len,addr}, len payload bytes from a
// show-ahead buffer, then an XOR parity byte. busy=1 holds the current byte.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | ready, waiting for a legal start
// S_HEADER  | presenting header byte {len,addr}
// S_PAYLOAD | streaming payload bytes, popping the buffer
// S_PARITY  | presenting parity (inverted if err_inject latched)
// S_DONE    | one-cycle done pulse, packet counted
module router_pkt_gen (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  addr,
  input  logic [5:0]  len,
  input  logic        err_inject,
  input  logic [7:0]  pl_data,
  output logic        pl_rd,
  input  logic        busy,
  output logic        pkt_valid,
  output logic [7:0]  data_out,
  output logic        ready,
  output logic        done,
  output logic        cfg_err,
  output logic [15:0] pkt_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  addr_q;
  logic [5:0]  len_q;
  logic        err_q;
  logic [7:0]  parity_q;
  logic [5:0]  cnt_q;
  logic        cfg_err_q;
  logic        req_legal;
  logic        last_byte;

  assign req_legal = (addr != 2'd3) && (len != 6'd0);
  assign last_byte = (cnt_q == (len_q - 6'd1));
  assign cfg_err   = cfg_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= 2'd0;
      len_q     <= 6'd0;
      err_q     <= 1'b0;
      parity_q  <= 8'd0;
      cnt_q     <= 6'd0;
      cfg_err_q <= 1'b0;
      pkt_count <= 16'd0;
    end else begin
      state     <= state_nxt;
      cfg_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (req_legal) begin
              addr_q <= addr;
              len_q  <= len;
              err_q  <= err_inject;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_HEADER: begin
          if (!busy) begin
            parity_q <= {len_q, addr_q};
            cnt_q    <= 6'd0;
          end
        end
        S_PAYLOAD: begin
          if (!busy) begin
            parity_q <= parity_q ^ pl_data;
            cnt_q    <= cnt_q + 6'd1;
          end
        end
        S_DONE: pkt_count <= pkt_count + 16'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    pkt_valid = 1'b0;
    data_out  = 8'h00;
    pl_rd     = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start && req_legal) state_nxt = S_HEADER;
      end
      S_HEADER: begin
        pkt_valid = 1'b1;
        data_out  = {len_q, addr_q};
        if (!busy) state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        pkt_valid = 1'b1;
        data_out  = pl_data;
        pl_rd     = ~busy;
        if (!busy && last_byte) state_nxt = S_PARITY;
      end
      S_PARITY: begin
        data_out = err_q ? ~parity_q : parity_q;
        if (!busy) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
